// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parameterised up/down counter with wrap or saturate at the limits
// Optional sticky limit flag (clr_sticky/sticky ports) when PUDC_STICKY_EN is defined.
module param_updown_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = 0
) (
`ifdef PUDC_STICKY_EN
  input  logic             clr_sticky,
  output logic             sticky,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             limit_p
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             limit_q, limit_d;

  always_comb begin
    count_d = count_q;
    limit_d = 1'b0;
    if (load) begin
      // Out-of-range load values clamp so count never exceeds MAX_VAL
      count_d = (data > MAX_VAL) ? MAX_VAL : data;
    end else if (en) begin
      if (up) begin
        if (count_q == MAX_VAL) begin
          limit_d = 1'b1;
          count_d = (SATURATE != 0) ? MAX_VAL : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          limit_d = 1'b1;
          count_d = (SATURATE != 0) ? '0 : MAX_VAL;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      limit_q <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

`ifdef PUDC_STICKY_EN
  logic sticky_q, sticky_d;

  // A new limit event beats a simultaneous clear
  always_comb begin
    sticky_d = sticky_q;
    if (limit_d)         sticky_d = 1'b1;
    else if (clr_sticky) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign sticky = sticky_q;
`endif

  assign count   = count_q;
  assign limit_p = limit_q;
  assign at_max  = (count_q == MAX_VAL);
  assign at_min  = (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - scoreboard bench for wrap and saturate counters (WIDTH=4, MAX_VAL=9)
// Sticky checks are built in when PUDC_STICKY_EN is defined.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n, load, en, up, clr_sticky;
  logic [3:0] data;
  logic [3:0] count0, count1;
  logic       at_max0, at_min0, limit0, at_max1, at_min1, limit1;
  logic       sticky0, sticky1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    logic [3:0] c0;
    logic       l0;
    logic       s0;
    logic [3:0] c1;
    logic       l1;
    logic       s1;
    logic       cs;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) u_wrap (
`ifdef PUDC_STICKY_EN
    .clr_sticky(clr_sticky),
    .sticky    (sticky0),
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .data   (data),
    .en     (en),
    .up     (up),
    .count  (count0),
    .at_max (at_max0),
    .at_min (at_min0),
    .limit_p(limit0)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) u_sat (
`ifdef PUDC_STICKY_EN
    .clr_sticky(clr_sticky),
    .sticky    (sticky1),
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .data   (data),
    .en     (en),
    .up     (up),
    .count  (count1),
    .at_max (at_max1),
    .at_min (at_min1),
    .limit_p(limit1)
  );

`ifndef PUDC_STICKY_EN
  assign sticky0 = 1'b0;
  assign sticky1 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input string n, input logic ld, input logic [3:0] d, input logic e,
                      input logic u, input logic clr,
                      input logic [3:0] c0, input logic l0, input logic s0,
                      input logic [3:0] c1, input logic l1, input logic s1, input logic cs);
    exp_t x;
    @(negedge clk);
    load = ld; data = d; en = e; up = u; clr_sticky = clr;
    x.name = n; x.c0 = c0; x.l0 = l0; x.s0 = s0; x.c1 = c1; x.l1 = l1; x.s1 = s1; x.cs = cs;
    q.push_back(x);
  endtask

  // Monitor: every edge with a pending expectation is checked just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, " wrap count"},  32'(count0),  32'(e.c0));
        chk({e.name, " wrap limit"},  32'(limit0),  32'(e.l0));
        chk({e.name, " wrap at_max"}, 32'(at_max0), 32'(e.c0 == 4'd9));
        chk({e.name, " wrap at_min"}, 32'(at_min0), 32'(e.c0 == 4'd0));
        chk({e.name, " sat count"},   32'(count1),  32'(e.c1));
        chk({e.name, " sat limit"},   32'(limit1),  32'(e.l1));
        chk({e.name, " sat at_max"},  32'(at_max1), 32'(e.c1 == 4'd9));
        chk({e.name, " sat at_min"},  32'(at_min1), 32'(e.c1 == 4'd0));
`ifdef PUDC_STICKY_EN
        if (e.cs) begin
          chk({e.name, " wrap sticky"}, 32'(sticky0), 32'(e.s0));
          chk({e.name, " sat sticky"},  32'(sticky1), 32'(e.s1));
        end
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; clr_sticky = 1'b0; data = 4'd0;
    #2;
    chk("reset wrap count", 32'(count0), 0);
    chk("reset wrap limit", 32'(limit0), 0);
    chk("reset sat count",  32'(count1), 0);
    chk("reset at_min",     32'(at_min0), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up 12 times: wrap passes 9->0, saturate sticks at 9
    for (int i = 1; i <= 12; i++) begin
      step($sformatf("up%0d", i), 0, 4'd0, 1, 1, 0,
           4'(i % 10), (i == 10), 0,
           (i > 9) ? 4'd9 : 4'(i), (i >= 10), 0, 0);
    end

    step("load_clamp", 1, 4'hF, 0, 0, 0, 4'd9, 0, 0, 4'd9, 0, 0, 0);
    step("max_up",     0, 4'd0, 1, 1, 0, 4'd0, 1, 0, 4'd9, 1, 0, 0);
    step("hold",       0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 4'd9, 0, 0, 0);
    step("load_zero",  1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0);
    step("dn1",        0, 4'd0, 1, 0, 0, 4'd9, 1, 0, 4'd0, 1, 0, 0);
    step("dn2",        0, 4'd0, 1, 0, 0, 4'd8, 0, 0, 4'd0, 1, 0, 0);
    step("dn3",        0, 4'd0, 1, 0, 0, 4'd7, 0, 0, 4'd0, 1, 0, 0);
    step("load_en",    1, 4'd5, 1, 1, 0, 4'd5, 0, 0, 4'd5, 0, 0, 0);
    step("up6",        0, 4'd0, 1, 1, 0, 4'd6, 0, 0, 4'd6, 0, 0, 0);
    step("dn5",        0, 4'd0, 1, 0, 0, 4'd5, 0, 0, 4'd5, 0, 0, 0);
    step("up6b",       0, 4'd0, 1, 1, 0, 4'd6, 0, 0, 4'd6, 0, 0, 0);
    step("up7",        0, 4'd0, 1, 1, 0, 4'd7, 0, 0, 4'd7, 0, 0, 0);

    // Asynchronous reset between edges, then held across an edge with a pending load
    @(negedge clk);
    load = 1'b0; en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst wrap count", 32'(count0), 0);
    chk("async rst sat count",  32'(count1), 0);
    chk("async rst limit",      32'(limit0), 0);
    load = 1'b1; data = 4'd3; en = 1'b1; up = 1'b1;
    @(posedge clk);
    #1;
    chk("rst edge discard wrap", 32'(count0), 0);
    chk("rst edge discard sat",  32'(count1), 0);
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0; en = 1'b0;

    step("post_rst_up", 0, 4'd0, 1, 1, 0, 4'd1, 0, 0, 4'd1, 0, 0, 0);
    step("turn_dn",     0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0);
    step("turn_up",     0, 4'd0, 1, 1, 0, 4'd1, 0, 0, 4'd1, 0, 0, 0);

`ifdef PUDC_STICKY_EN
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("sticky rst", 32'(sticky0), 0);
    #2 rst_n = 1'b1;
    step("s_load9",   1, 4'd9, 0, 0, 0, 4'd9, 0, 0, 4'd9, 0, 0, 1);
    step("s_wrap",    0, 4'd0, 1, 1, 0, 4'd0, 1, 1, 4'd9, 1, 1, 1);
    step("s_clr_evt", 0, 4'd0, 1, 0, 1, 4'd9, 1, 1, 4'd8, 0, 0, 1);
    step("s_clr",     0, 4'd0, 0, 0, 1, 4'd9, 0, 0, 4'd8, 0, 0, 1);
`endif

    @(negedge clk);
    load = 1'b0; en = 1'b0; clr_sticky = 1'b0;
    @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
